eth_pack: RTL and testbench
===========================

# eth_pack

Downstream frame builder for the `cs_num` length decoder. On each `fs`/`fd` transaction it latches the lengths `cs_num` decodes from `cmd_kdev`, accepts the ADC byte stream for that transaction into a local FIFO, and emits one fixed-length Ethernet payload frame on a byte stream. The frame is a header, then ADC data, then zero padding, then an optional checksum. It sits between `cs_num`/the ADC receive path and the Ethernet MAC transmit interface.

## Interface
Parameters:
- `FIFO_AW`, 10: FIFO address width. Depth is 2^FIFO_AW bytes, which must be at least the maximum `adc_rx_len`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `fs` in 1: start. Level held high by the controller for the whole transaction.
- `fd` out 1: done. Four-phase acknowledge for `fs`.
- `adc_rx_len` in 10: number of ADC bytes in this transaction, from `cs_num`.
- `eth_tx_len` in 12: total frame length in bytes, from `cs_num`.
- `data_cnt` in 8: data count copied into the header, from `cs_num`.
- `adc_rxd` in 8: ADC byte.
- `adc_rxv` in 1: ADC byte valid.
- `adc_rxr` out 1: ready for an ADC byte.
- `eth_txd` out 8: frame byte.
- `eth_txv` out 1: frame byte valid.
- `eth_txr` in 1: MAC ready.

## Operation
- **Overhead.** OVH = 4, or 5 with `CHECKSUM_EN`.
- **Header.** The header is 0x55, 0xAA, `data_cnt`, `seq`.
  - `seq` is an 8-bit frame counter that increments when a frame completes. It wraps 255→0.
- **Latched lengths.** On leaving IDLE the block latches L = max(`eth_tx_len`, OVH), A = `adc_rx_len` and D = `data_cnt`. The ports are ignored after that.
- **Section lengths.** All arithmetic is 12-bit unsigned.
  - PAY = min(A, L−OVH).
  - PAD = L−OVH−PAY.
- **ADC input.** `adc_rxr` = busy && FIFO not full && in_cnt < A.
  - A byte is consumed when `adc_rxv && adc_rxr`.
  - Bytes with index ≥ PAY are consumed but not written to the FIFO.
  - Bytes beyond A are never consumed.
- **FSM states and transitions:**
  - IDLE: `fs`=1 → HEAD.
  - HEAD: 4 bytes → DATA. If PAY=0, go to PAD instead; if PAD is also 0, go to CSUM or DONE.
  - DATA: pops the FIFO; PAY bytes → PAD (or CSUM/DONE when PAD=0).
  - PAD: sends PAD bytes of 0x00 → CSUM (or DONE).
  - CSUM: sends 1 byte → DONE. This state exists only with `CHECKSUM_EN`.
  - DONE: holds `fd`=1. Leaves to IDLE only when `fs`=0 **and** in_cnt = A, so all input is drained.
- **DATA stall.** In DATA, when the FIFO is empty, `eth_txv`=0. This is a bubble, not an error.
- **`fs` drop mid-frame.** Dropping `fs` before DONE is ignored; the frame completes.
- **Reset.** `rst` at any time: FSM→IDLE, FIFO flushed, `seq`=0, and all counters = 0.

## Timing
- **Reset values.** `fd`=0, `adc_rxr`=0, `eth_txv`=0, `eth_txd`=0x00.
- **Start latency.** `fs` sampled high in IDLE at edge N gives `eth_txv`=1 with byte 0x55 after edge N+1.
- **Output handshake.** A byte transfers on an edge with `eth_txv && eth_txr`.
  - While `eth_txr`=0, `eth_txd`/`eth_txv` are held stable.
  - Throughput is 1 byte/cycle.
- **Outputs are registered.** `eth_txd` and `eth_txv` come from flops.
- **FIFO latency.** The FIFO has 1-cycle read latency. A byte written at edge k is available at the output no earlier than edge k+2.
- **Done.**
  - `fd` rises on the edge after the last frame byte transfers, provided input is drained; otherwise it rises later, once the drain condition is met.
  - `fd` falls on the edge after `fs` is sampled low. IDLE is re-entered on that same edge.
  - A new `fs`=1 is accepted no earlier than the following cycle.
- **Frame length.** `eth_txv` frames total exactly L transfers.

## Configuration
- **`ETH_PACK_CHECKSUM_EN` defined:**
  - OVH=5.
  - The final byte is the XOR of all L−1 preceding frame bytes, header included.
- **Not defined:**
  - OVH=4.
  - No CSUM state and no checksum logic.
  - The frame ends after padding.

## Structure
- **Shared package** (`eth_pack_pkg`):
  - FSM state enum.
  - Header constants SYNC0=0x55 and SYNC1=0xAA.
  - HDR_LEN=4.
- **Sub-module:** `eth_pack_fifo`, a synchronous FIFO with parameter AW, 8-bit data, full/empty flags, registered read data and a flush input.

## Test plan
- **Nominal frame.** `eth_tx_len`=20, `adc_rx_len`=8, `data_cnt`=3, bytes 0x01..0x08, `eth_txr`=1 → frame 55 AA 03 00 01..08, then PAD zeros, then checksum.
  - With the macro: 7 zeros, then the XOR byte. Without it: 8 zeros.
  - `fd` high after the last byte.
  - Next frame header `seq`=01.
- **Truncation.** `eth_tx_len`=10, `adc_rx_len`=16, no checksum → header plus the first 6 ADC bytes. All 16 bytes are consumed, and `fd` waits until the 16th.
- **Backpressure.** Toggle `eth_txr` 1-on/2-off → identical byte sequence, and `eth_txd` is stable while `eth_txr`=0.
- **Starved input.** ADC bytes arrive every 5 cycles → bubbles in DATA only, and the frame content is unchanged.
- **Minimum and degenerate lengths.** `eth_tx_len`=2, `adc_rx_len`=0 → a frame of OVH bytes, header only (plus checksum with the macro).
- **Reset mid-DATA.** Assert `rst` after 3 payload bytes → all outputs at reset values. The next `fs` produces a clean frame with `seq`=00.

Source files
------------

// File: rtl/eth_pack_pkg.sv
// Shared types and constants for the eth_pack frame builder.
// ETH_PACK_CHECKSUM_EN adds a trailing XOR checksum byte and the CSUM state.
package eth_pack_pkg;

  localparam logic [7:0]  SYNC0   = 8'h55;
  localparam logic [7:0]  SYNC1   = 8'hAA;
  localparam logic [11:0] HDR_LEN = 12'd4;

`ifdef ETH_PACK_CHECKSUM_EN
  localparam logic [11:0] OVH = 12'd5;
`else
  localparam logic [11:0] OVH = 12'd4;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_DATA,
    S_PAD,
`ifdef ETH_PACK_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  // State that follows the last padding byte (or the payload when there is no padding).
  function automatic state_t end_state();
`ifdef ETH_PACK_CHECKSUM_EN
    return S_CSUM;
`else
    return S_DONE;
`endif
  endfunction

  function automatic state_t tail_state(input logic [11:0] pad);
    if (pad != 12'd0) return S_PAD;
    return end_state();
  endfunction

endpackage

// File: rtl/eth_pack_fifo.sv
// Synchronous byte FIFO with registered read data (1-cycle read latency) and flush.
module eth_pack_fifo #(
  parameter int AW = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_en,
  output logic [7:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  r_mem [2**AW];
  logic [AW:0] r_wp;
  logic [AW:0] r_rp;
  logic [7:0]  r_rd_data;
  logic        w_wr;
  logic        w_rd;

  assign o_empty   = (r_wp == r_rp);
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + PTR_ONE;
      if (w_rd) r_rp <= r_rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= i_wr_data;
    if (w_rd) r_rd_data <= r_mem[r_rp[AW-1:0]];
  end

endmodule

// File: rtl/eth_pack.sv
// Fixed-length Ethernet payload frame builder: header, ADC data, zero pad, optional checksum.
// Optional checksum byte enabled by defining ETH_PACK_CHECKSUM_EN.
module eth_pack
  import eth_pack_pkg::*;
#(
  parameter int FIFO_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [9:0]  adc_rx_len,
  input  logic [11:0] eth_tx_len,
  input  logic [7:0]  data_cnt,
  input  logic [7:0]  adc_rxd,
  input  logic        adc_rxv,
  output logic        adc_rxr,
  output logic [7:0]  eth_txd,
  output logic        eth_txv,
  input  logic        eth_txr
);

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_len;
  logic [11:0] r_alen;
  logic [7:0]  r_dcnt;
  logic [7:0]  r_seq;
  logic [11:0] r_cnt;
  logic [11:0] r_in_cnt;
  logic [11:0] r_pop_cnt;
  logic        r_rd_vld;
  logic        r_txv;
  logic [7:0]  r_txd;
  logic        r_fd;
`ifdef ETH_PACK_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic [11:0] w_body;
  logic [11:0] w_pay;
  logic [11:0] w_pad;
  logic        w_start;
  logic        w_out_free;
  logic        w_load;
  logic [7:0]  w_byte;
  logic        w_rxr;
  logic        w_consume;
  logic        w_wr_en;
  logic        w_rd_en;
  logic [7:0]  w_rd_data;
  logic        w_full;
  logic        w_empty;

  assign w_body     = r_len - OVH;
  assign w_pay      = (r_alen < w_body) ? r_alen : w_body;
  assign w_pad      = w_body - w_pay;
  assign w_start    = (r_state == S_IDLE) && fs;
  assign w_out_free = !r_txv || eth_txr;

  assign w_rxr      = (r_state != S_IDLE) && !w_full && (r_in_cnt < r_alen);
  assign w_consume  = adc_rxv && w_rxr;
  // Bytes past the payload length are swallowed so the source can finish its burst.
  assign w_wr_en    = w_consume && (r_in_cnt < w_pay);
  // FIFO read data doubles as the holding register; prefetch during HEAD avoids a bubble.
  assign w_rd_en    = ((r_state == S_HEAD) || (r_state == S_DATA)) && !w_empty &&
                      (r_pop_cnt < w_pay) && (!r_rd_vld || ((r_state == S_DATA) && w_load));

  assign adc_rxr = w_rxr;
  assign eth_txd = r_txd;
  assign eth_txv = r_txv;
  assign fd      = r_fd;

  eth_pack_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (w_start),
    .i_wr_en   (w_wr_en),
    .i_wr_data (adc_rxd),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_byte = 8'h00;
    case (r_state)
      S_IDLE: if (fs) w_next = S_HEAD;
      S_HEAD: begin
        w_load = w_out_free;
        case (r_cnt[1:0])
          2'd0:    w_byte = SYNC0;
          2'd1:    w_byte = SYNC1;
          2'd2:    w_byte = r_dcnt;
          default: w_byte = r_seq;
        endcase
        if (w_load && (r_cnt == HDR_LEN - 12'd1))
          w_next = (w_pay != 12'd0) ? S_DATA : tail_state(w_pad);
      end
      S_DATA: begin
        w_load = w_out_free && r_rd_vld;
        w_byte = w_rd_data;
        if (w_load && (r_cnt == w_pay - 12'd1)) w_next = tail_state(w_pad);
      end
      S_PAD: begin
        w_load = w_out_free;
        if (w_load && (r_cnt == w_pad - 12'd1)) w_next = end_state();
      end
`ifdef ETH_PACK_CHECKSUM_EN
      S_CSUM: begin
        w_load = w_out_free;
        w_byte = r_csum;
        if (w_load) w_next = S_DONE;
      end
`endif
      S_DONE: if (r_fd && !fs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction parameters are captured once per frame and never reset.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_len  <= (eth_tx_len < OVH) ? OVH : eth_tx_len;
      r_alen <= {2'b00, adc_rx_len};
      r_dcnt <= data_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_in_cnt  <= '0;
      r_pop_cnt <= '0;
      r_rd_vld  <= 1'b0;
      r_txv     <= 1'b0;
      r_txd     <= 8'h00;
      r_fd      <= 1'b0;
      r_seq     <= 8'h00;
    end else begin
      if (w_start) begin
        r_in_cnt  <= '0;
        r_pop_cnt <= '0;
        r_rd_vld  <= 1'b0;
      end else begin
        if (w_consume) r_in_cnt <= r_in_cnt + 12'd1;
        if (w_rd_en) r_pop_cnt <= r_pop_cnt + 12'd1;
        if (w_rd_en) r_rd_vld <= 1'b1;
        else if ((r_state == S_DATA) && w_load) r_rd_vld <= 1'b0;
      end

      if (w_next != r_state) r_cnt <= '0;
      else if (w_load)       r_cnt <= r_cnt + 12'd1;

      if (w_load) begin
        r_txv <= 1'b1;
        r_txd <= w_byte;
      end else if (w_out_free) begin
        r_txv <= 1'b0;
      end

      // Done only once the last byte has left and every ADC byte was taken.
      if (r_state == S_DONE) begin
        if (r_fd && !fs) begin
          r_fd <= 1'b0;
        end else if (!r_fd && w_out_free && (r_in_cnt == r_alen)) begin
          r_fd  <= 1'b1;
          r_seq <= r_seq + 8'd1;
        end
      end
    end
  end

`ifdef ETH_PACK_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_csum <= 8'h00;
    else if (w_start) r_csum <= 8'h00;
    else if (w_load)  r_csum <= r_csum ^ w_byte;
  end
`endif

endmodule

// File: tb/tb_eth_pack.sv
// Self-checking bench for eth_pack: table of frame scenarios plus a reset-mid-frame sequence.
module tb_eth_pack;

`ifdef ETH_PACK_CHECKSUM_EN
  localparam int OVH = 5;
`else
  localparam int OVH = 4;
`endif
  localparam int HDR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic        fd;
  logic [9:0]  adc_rx_len;
  logic [11:0] eth_tx_len;
  logic [7:0]  data_cnt;
  logic [7:0]  adc_rxd;
  logic        adc_rxv;
  logic        adc_rxr;
  logic [7:0]  eth_txd;
  logic        eth_txv;
  logic        eth_txr;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  q_exp[$];
  logic [7:0]  exp_seq;

  typedef struct {
    int txlen;
    int alen;
    int dcnt;
    int gap;
    int bp;
    int exp_len;
  } vec_t;

  vec_t vecs[7];

  eth_pack #(.FIFO_AW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .fs         (fs),
    .fd         (fd),
    .adc_rx_len (adc_rx_len),
    .eth_tx_len (eth_tx_len),
    .data_cnt   (data_cnt),
    .adc_rxd    (adc_rxd),
    .adc_rxv    (adc_rxv),
    .adc_rxr    (adc_rxr),
    .eth_txd    (eth_txd),
    .eth_txv    (eth_txv),
    .eth_txr    (eth_txr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference frame: header, ADC bytes i+1, zero pad, optional XOR of everything before.
  task automatic build_frame(input int txlen, input int alen, input int dcnt);
    int l, pay, pad;
    logic [7:0] cs;
    logic [7:0] b;
    l   = (txlen < OVH) ? OVH : txlen;
    pay = (alen < l - OVH) ? alen : l - OVH;
    pad = l - OVH - pay;
    cs  = 8'h00;
    q_exp.delete();
    for (int i = 0; i < HDR + pay + pad; i++) begin
      if (i == 0)        b = 8'h55;
      else if (i == 1)   b = 8'hAA;
      else if (i == 2)   b = 8'(dcnt);
      else if (i == 3)   b = exp_seq;
      else if (i < HDR + pay) b = 8'(i - HDR + 1);
      else               b = 8'h00;
      cs = cs ^ b;
      q_exp.push_back(b);
    end
    if (OVH == 5) q_exp.push_back(cs);
  endtask

  task automatic run_frame(input int txlen, input int alen, input int dcnt,
                           input int gap, input int bp, input int exp_len, input int abort);
    int   idx, nx, cyc, last_x, l, pay;
    logic p_v, p_r;
    logic [7:0] p_d;
    bit   fd_seen, drained_at_last;
    idx = 0; nx = 0; cyc = 0; last_x = -1;
    p_v = 1'b0; p_r = 1'b0; p_d = 8'h00;
    fd_seen = 1'b0; drained_at_last = 1'b0;
    l   = (txlen < OVH) ? OVH : txlen;
    pay = (alen < l - OVH) ? alen : l - OVH;
    build_frame(txlen, alen, dcnt);
    @(negedge clk);
    eth_tx_len = 12'(txlen);
    adc_rx_len = 10'(alen);
    data_cnt   = 8'(dcnt);
    adc_rxv    = 1'b0;
    eth_txr    = 1'b1;
    fs         = 1'b1;
    while (!fd_seen && cyc < 3000) begin
      @(negedge clk);
      if (cyc == 0) check("start_txv_low", 32'(eth_txv), 32'd0);
      if (cyc == 1) begin
        check("start_txv", 32'(eth_txv), 32'd1);
        check("start_byte", 32'(eth_txd), 32'h55);
      end
      if (p_v && !p_r) begin
        check("hold_txd", 32'(eth_txd), 32'(p_d));
        check("hold_txv", 32'(eth_txv), 32'd1);
      end
      if (fd) begin
        fd_seen = 1'b1;
        adc_rxv = 1'b0;
        check("fd_after_last", 32'(q_exp.size()), 32'd0);
        check("fd_after_drain", 32'(idx), 32'(alen));
        if (drained_at_last) check("fd_latency", 32'(cyc - last_x <= 2), 32'd1);
      end else begin
        eth_txr = (bp != 0) ? ((cyc % 3) == 0) : 1'b1;
        adc_rxv = (idx < alen) && (cyc >= idx * gap);
        adc_rxd = 8'(idx + 1);
        if (adc_rxv && adc_rxr) idx++;
        if (cyc >= 2 && q_exp.size() != 0 && !eth_txv)
          check("bubble_in_data", 32'((nx >= HDR) && (nx < HDR + pay)), 32'd1);
        if (eth_txv && eth_txr) begin
          if (q_exp.size() == 0) check("extra_byte", 32'd1, 32'd0);
          else check("frame_byte", 32'(eth_txd), 32'(q_exp.pop_front()));
          nx++;
          last_x = cyc;
          if (q_exp.size() == 0) drained_at_last = (idx == alen);
        end
        p_v = eth_txv; p_r = eth_txr; p_d = eth_txd;
        if (abort > 0 && nx >= abort) break;
      end
      cyc++;
    end
    if (abort > 0) return;
    if (!fd_seen) check("fd_timeout", 32'd0, 32'd1);
    check("frame_len", 32'(nx), 32'(exp_len));
    fs = 1'b0;
    @(negedge clk);
    check("fd_fall", 32'(fd), 32'd0);
    check("idle_txv", 32'(eth_txv), 32'd0);
    exp_seq = exp_seq + 8'd1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fs = 1'b0; adc_rxv = 1'b0; adc_rxd = 8'h00; eth_txr = 1'b1;
    adc_rx_len = '0; eth_tx_len = '0; data_cnt = '0;
    exp_seq = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_fd", 32'(fd), 32'd0);
    check("rst_rxr", 32'(adc_rxr), 32'd0);
    check("rst_txv", 32'(eth_txv), 32'd0);
    check("rst_txd", 32'(eth_txd), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{txlen: 20,  alen: 8,   dcnt: 3, gap: 1, bp: 0, exp_len: 20};
    vecs[1] = '{txlen: 20,  alen: 8,   dcnt: 3, gap: 1, bp: 0, exp_len: 20};
    vecs[2] = '{txlen: 10,  alen: 16,  dcnt: 7, gap: 1, bp: 0, exp_len: 10};
    vecs[3] = '{txlen: 20,  alen: 8,   dcnt: 3, gap: 1, bp: 1, exp_len: 20};
    vecs[4] = '{txlen: 20,  alen: 8,   dcnt: 5, gap: 5, bp: 0, exp_len: 20};
    vecs[5] = '{txlen: 2,   alen: 0,   dcnt: 9, gap: 1, bp: 0, exp_len: OVH};
    vecs[6] = '{txlen: 300, alen: 200, dcnt: 1, gap: 1, bp: 0, exp_len: 300};

    for (int v = 0; v < 7; v++)
      run_frame(vecs[v].txlen, vecs[v].alen, vecs[v].dcnt,
                vecs[v].gap, vecs[v].bp, vecs[v].exp_len, 0);

    // Reset after three payload bytes have gone out (header + 3 transfers).
    run_frame(20, 8, 3, 1, 0, 20, HDR + 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_fd", 32'(fd), 32'd0);
    check("midrst_rxr", 32'(adc_rxr), 32'd0);
    check("midrst_txv", 32'(eth_txv), 32'd0);
    check("midrst_txd", 32'(eth_txd), 32'd0);
    fs = 1'b0; adc_rxv = 1'b0; eth_txr = 1'b1;
    q_exp.delete();
    exp_seq = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(20, 8, 3, 1, 0, 20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
